display_scan_driver: RTL
========================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles per digit slot; legal range 2..256.
REQ-002 Parameter BLINK_FRAMES, default 64, scan frames per blink half-period; legal range 1..1024.
REQ-003 Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tens_hours  in  2  leftmost digit (0-2).
- units_hours  in  4  hours units digit.
- tens_minutes  in  3  minutes tens digit.
- units_minutes  in  4  rightmost digit.
- setting_mode_en  in  1  time-setting mode active.
- alarm_mode_en  in  1  alarm-setting mode active.
- setting_digit  in  2  digit under edit: 0 = tens_hours ... 3 = units_minutes.
- alarm_sound  in  1  alarm request from the clock core.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  out  4  digit anodes, active-low; an_n[3] = leftmost.
- dp_n  out  1  colon/decimal point, active-low.
- buzzer  out  1  buzzer drive, active-high.

Function
REQ-004 The block SHALL keep a slot counter cnt (0..SCAN_DIV-1) and a digit index idx (0..3).
- cnt increments every cycle.
- At cnt = SCAN_DIV-1, cnt SHALL return to 0 and idx SHALL advance 0->1->2->3->0.
REQ-005 A frame SHALL be 4*SCAN_DIV cycles. A frame ends on the cycle where idx = 3 and cnt = SCAN_DIV-1.
REQ-006 At each frame end, the block SHALL latch all four digit inputs into shadow registers. Input changes inside a frame SHALL NOT affect the display until the next frame.
REQ-007 The block SHALL keep a frame counter (0..BLINK_FRAMES-1) that increments at each frame end.
- At wrap, blink_phase SHALL toggle.
- After reset, blink_phase = 0.
REQ-008 All outputs SHALL be registered, one cycle behind the cnt/idx/blink_phase state that produces them.
REQ-009 When cnt = 0 (first cycle of every slot), an_n SHALL be 4'b1111 and seg_n SHALL be 7'h7F. This is the anti-ghosting blank.
REQ-010 When cnt != 0:
- an_n SHALL assert exactly one bit: idx 0 -> 0111, 1 -> 1011, 2 -> 1101, 3 -> 1110.
- seg_n SHALL show the decoded shadow digit for that idx.
REQ-011 Decode (seg_n hex):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Any value above 9 SHALL show a dash, 3F.
REQ-012 Blink: if (setting_mode_en or alarm_mode_en), blink_phase = 1, and idx = setting_digit, that slot SHALL be fully blanked (an_n = 1111, seg_n = 7F).
- Other slots are unaffected.
- Both modes asserted together behave as one mode asserted.
REQ-013 dp_n SHALL be 1 in every slot except idx = 1 with cnt != 0. In that slot:
- Normal mode (neither mode enable high): dp_n = blink_phase, i.e. the colon blinks.
- Setting or alarm mode: dp_n = 0 (steady), even while the digit itself is blink-blanked.
REQ-014 buzzer SHALL be registered as alarm_sound AND NOT blink_phase AND NOT setting_mode_en AND NOT alarm_mode_en. This gives an on/off beep at the blink rate.
REQ-015 The worst-case latency from a digit input change to the pins SHALL be at most 2 frames + 1 cycle.

Reset
REQ-016 While rst = 1 at a clock edge, the next state SHALL be:
- cnt = 0, idx = 0, frame counter = 0, blink_phase = 0, all shadow digits = 0;
- an_n = 1111, seg_n = 7F, dp_n = 1, buzzer = 0.
REQ-017 Reset asserted mid-slot or mid-frame SHALL take effect on that edge with no partial-slot completion. After release, scanning SHALL restart at idx 0, cnt 0.
REQ-018 The first frame after reset SHALL display 0000, because the shadows are zero.

Verification
(Scenarios use SCAN_DIV = 4, BLINK_FRAMES = 2.)
REQ-019 Reset release with inputs 1,2,3,4 held:
- Frame 1 shows 0000.
- Frame 2, per slot: an_n 1111 for 1 cycle, then 0111 for 3 cycles with seg_n 79; 1011/24; 1101/30; 1110/19.
REQ-020 Change units_minutes from 4 to 7 at mid-frame, in slot 1 -> slot 3 still shows 19 in the current frame and shows 78 from the next frame.
REQ-021 units_minutes = 12 -> slot 3 seg_n = 3F.
REQ-022 setting_mode_en = 1, setting_digit = 2 -> slot 2 is blanked in frames where blink_phase = 1 (2 of every 4 frames). In slot 1, dp_n = 0 in every frame.
REQ-023 alarm_sound = 1 in normal mode -> buzzer alternates 2 frames high, 2 frames low. Raising alarm_mode_en forces buzzer to 0 on the next cycle.
REQ-024 rst pulse at cnt = 2, idx = 2 -> the next cycle shows an_n 1111 and seg_n 7F, and scanning resumes at idx 0 with the first frame showing 0000.

Source files
------------

// File: rtl/display_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver for an HH:MM clock display.
// Adds anti-ghosting blanking, edit-digit blinking, colon control and a beeping buzzer.
module display_scan_driver #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tens_hours,
    input  logic [3:0] units_hours,
    input  logic [2:0] tens_minutes,
    input  logic [3:0] units_minutes,
    input  logic       setting_mode_en,
    input  logic       alarm_mode_en,
    input  logic [1:0] setting_digit,
    input  logic       alarm_sound,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n,
    output logic       buzzer
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [FW-1:0]   r_frame;
    logic            r_blink;
    logic [3:0][3:0] r_shadow;

    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_frame_wrap;
    logic       w_mode;
    logic       w_blank;
    logic       w_dp_slot;
    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic [3:0] w_an;
    logic       w_dp;
    logic       w_buzz;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    assign w_slot_end   = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_frame_end  = w_slot_end && (r_idx == 2'd3);
    assign w_frame_wrap = (r_frame == FW'(BLINK_FRAMES - 1));
    assign w_mode       = setting_mode_en | alarm_mode_en;

    // First cycle of each slot is dark so the previous digit cannot ghost into the next anode.
    assign w_blank   = (r_cnt == '0) || (w_mode && r_blink && (r_idx == setting_digit));
    assign w_dp_slot = (r_idx == 2'd1) && (r_cnt != '0);
    assign w_digit   = r_shadow[r_idx];

    always_comb begin
        w_an = 4'b1111;
        case (r_idx)
            2'd0: w_an = 4'b0111;
            2'd1: w_an = 4'b1011;
            2'd2: w_an = 4'b1101;
            2'd3: w_an = 4'b1110;
            default: w_an = 4'b1111;
        endcase
        w_seg = seg_decode(w_digit);
        if (w_blank) begin
            w_an  = 4'b1111;
            w_seg = 7'h7F;
        end
    end

    // Colon stays lit during editing, even while the edited digit is blinked off.
    assign w_dp   = w_dp_slot ? (w_mode ? 1'b0 : r_blink) : 1'b1;
    assign w_buzz = alarm_sound & ~r_blink & ~w_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_frame  <= '0;
            r_blink  <= 1'b0;
            r_shadow <= '0;
            an_n     <= 4'b1111;
            seg_n    <= 7'h7F;
            dp_n     <= 1'b1;
            buzzer   <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
            if (w_slot_end)
                r_idx <= r_idx + 2'd1;
            if (w_frame_end) begin
                r_shadow[0] <= {2'b00, tens_hours};
                r_shadow[1] <= units_hours;
                r_shadow[2] <= {1'b0, tens_minutes};
                r_shadow[3] <= units_minutes;
                if (w_frame_wrap) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
            an_n   <= w_an;
            seg_n  <= w_seg;
            dp_n   <= w_dp;
            buzzer <= w_buzz;
        end
    end

endmodule
